instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage that sits directly upstream of the instruction register.
//  Holds the program counter and runs a req/ack read handshake to instruction memory.
//  Presents the fetched word with a one-cycle ir_load strobe, which the IR captures.
//  Applies branch redirects, detects memory timeouts, and flags them to the control unit.
// PARAMETERS
//  ADDR_W    16     PC / memory word-address width
//  DATA_W    32     instruction width
//  RESET_PC  0      PC value after reset
//  TIMEOUT   15     max cycles in REQ without mem_ack before fault (1..255)
// PORTS
//  clk        in   1       system clock, posedge active
//  rst_f      in   1       synchronous active-low reset
//  fetch_req  in   1       control requests next instruction; level, sampled only in IDLE
//  br_taken   in   1       redirect PC to br_addr (1-cycle pulse)
//  br_addr    in   ADDR_W  branch target word address
//  mem_req    out  1       memory read request
//  mem_addr   out  ADDR_W  memory read address; stable while mem_req=1
//  mem_ack    in   1       memory data valid this cycle; honoured only when mem_req=1
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ack
//  ir_load    out  1       one-cycle strobe to the IR: load ir_data
//  ir_data    out  DATA_W  registered fetched instruction
//  pc_out     out  ADDR_W  current PC: address of the next fetch
//  busy       out  1       1 in any state other than IDLE
//  fault      out  1       sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset (rst_f=0 at posedge):
//   - state=IDLE, pc=RESET_PC, ir_data=0, ir_load=0, mem_req=0, fault=0.
//   - Branch-pending flag and timeout counter are cleared.
//   - Reset has priority in every state, including mid-handshake. The in-flight request is dropped.
//  Unregistered outputs: mem_addr=pc, busy=(state!=IDLE), pc_out=pc.
//  State IDLE:
//   - fetch_req=1 -> REQ, with mem_req=1 from the next cycle.
//   - br_taken=1 -> pc<=br_addr in the same edge. Combined with fetch_req, the fetch uses br_addr.
//  State REQ:
//   - mem_req=1 and mem_addr=pc are held constant.
//   - The timeout counter increments each cycle.
//   - On mem_ack=1: ir_data<=mem_rdata, counter<=0, -> LOAD. mem_req falls on the same edge.
//   - If the counter reaches TIMEOUT with no ack: fault<=1, mem_req<=0, -> FAULT.
//  State LOAD:
//   - ir_load=1 for exactly this cycle, then -> IDLE.
//   - PC update on exit: pc<=pending ? pend_addr : pc+1, then pending<=0.
//   - pc+1 wraps modulo 2^ADDR_W (max -> 0).
//  State FAULT:
//   - mem_req=0, ir_load=0; fetch_req and br_taken are ignored.
//   - Left only by reset.
//  Branch while busy:
//   - br_taken in REQ or LOAD sets pending=1 and pend_addr=br_addr.
//   - A later br_taken before LOAD exits overwrites pend_addr (last wins).
//   - The in-progress fetch still completes and is delivered via ir_load. Control discards it.
//  Timing:
//   - fetch_req sampled to ir_load high is (2 + ack wait) cycles.
//   - With ack on the first REQ cycle, ir_load is high in cycle 3.
//   - Back-to-back fetches: one IDLE cycle minimum between LOAD and the next REQ.
//  mem_ack outside REQ is ignored. ir_data holds its value until the next ack.
// TESTING
//  1. Reset, fetch_req=1, mem_ack on first REQ cycle with rdata=0xA5A5_0001 -> mem_addr=0; ir_load pulses once with ir_data=0xA5A5_0001; pc_out=1.
//  2. Ack delayed 5 cycles -> mem_req and mem_addr=0x0003 stable for all 5 cycles; single ir_load; pc 3->4.
//  3. IDLE with br_taken=1, br_addr=0x0040 and fetch_req=1 -> fetch from 0x0040; pc_out=0x0041 after LOAD.
//  4. br_taken (0x0100) during REQ at pc=0x0010 -> fetch of 0x0010 delivered; pc_out=0x0100 after LOAD, not 0x0011.
//  5. No ack for TIMEOUT=15 cycles -> fault=1, mem_req=0, further fetch_req ignored; rst_f low clears everything, pc=RESET_PC.
//  6. pc=0xFFFF fetch completes -> pc_out=0x0000; rst_f asserted mid-REQ -> IDLE next edge, no ir_load.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the req/ack read to instruction memory,
// hands each fetched word to the IR with a one-cycle ir_load strobe, and flags memory timeouts.
module instr_fetch #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_req,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_load,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              fault
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StLoad, StFault} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_q, pend_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic [7:0]        cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pend_d      = pend_q;
        fault_d     = fault_q;
        ir_data_d   = ir_data_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                // A branch seen together with fetch_req steers this very fetch.
                if (br_taken) pc_d = br_addr;
                if (fetch_req) begin
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (br_taken) begin
                    pend_d      = 1'b1;
                    pend_addr_d = br_addr;
                end
                if (mem_ack) begin
                    ir_data_d = mem_rdata;
                    cnt_d     = '0;
                    state_d   = StLoad;
                end else if (cnt_q == TimeoutLast) begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StLoad: begin
                // A branch arriving in this last busy cycle still wins over older ones.
                if (br_taken)    pc_d = br_addr;
                else if (pend_q) pc_d = pend_addr_q;
                else             pc_d = pc_q + ADDR_W'(1);
                pend_d  = 1'b0;
                state_d = StIdle;
            end
            StFault: begin
                state_d = StFault;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q     <= StIdle;
            pc_q        <= ADDR_W'(RESET_PC);
            pend_addr_q <= '0;
            pend_q      <= 1'b0;
            fault_q     <= 1'b0;
            ir_data_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pend_q      <= pend_d;
            fault_q     <= fault_d;
            ir_data_q   <= ir_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req  = (state_q == StReq);
    assign ir_load  = (state_q == StLoad);
    assign mem_addr = pc_q;
    assign pc_out   = pc_q;
    assign busy     = (state_q != StIdle);
    assign fault    = fault_q;
    assign ir_data  = ir_data_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {address, word} pairs are queued when a fetch is
// launched and retired by a monitor when ir_load fires.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_req;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_load;
    logic [31:0] ir_data;
    logic [15:0] pc_out;
    logic        busy;
    logic        fault;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] sb_q[$];
    logic [15:0] ack_addr = '0;

    instr_fetch #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .RESET_PC(0),
        .TIMEOUT (15)
    ) u_dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .fetch_req(fetch_req),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ir_load  (ir_load),
        .ir_data  (ir_data),
        .pc_out   (pc_out),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        if (mem_req && mem_ack) ack_addr = mem_addr;
        if (ir_load) begin
            if (sb_q.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr", 32'(ack_addr), 32'(e[47:32]));
                check("sb_data", ir_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one fetch from IDLE, ack after wait_cyc silent REQ cycles, optionally branch.
    task automatic do_fetch(input int wait_cyc, input logic [31:0] data,
                            input logic [15:0] exp_addr, input logic [15:0] exp_pc,
                            input bit idle_br, input int n_br, input logic [15:0] br_base);
        sb_q.push_back({exp_addr, data});
        fetch_req = 1'b1;
        if (idle_br) begin
            br_taken = 1'b1;
            br_addr  = br_base;
        end
        tick();
        fetch_req = 1'b0;
        br_taken  = 1'b0;
        for (int i = 0; i <= wait_cyc; i++) begin
            check("req_high", 32'(mem_req), 32'd1);
            check("req_addr", 32'(mem_addr), 32'(exp_addr));
            check("no_early_load", 32'(ir_load), 32'd0);
            if (i < n_br) begin
                br_taken = 1'b1;
                br_addr  = br_base + 16'(i);
            end
            if (i == wait_cyc) begin
                mem_ack   = 1'b1;
                mem_rdata = data;
            end else begin
                mem_rdata = ~data;
            end
            tick();
            br_taken = 1'b0;
            mem_ack  = 1'b0;
        end
        check("load_high", 32'(ir_load), 32'd1);
        check("req_low", 32'(mem_req), 32'd0);
        tick();
        check("load_once", 32'(ir_load), 32'd0);
        check("pc_after", 32'(pc_out), 32'(exp_pc));
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_f     = 1'b0;
        fetch_req = 1'b0;
        br_taken  = 1'b0;
        br_addr   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst_f = 1'b1;
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_load", 32'(ir_load), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_irdata", ir_data, 32'd0);

        // Immediate ack, then walk pc up to 3.
        do_fetch(0, 32'hA5A5_0001, 16'h0000, 16'h0001, 1'b0, 0, 16'h0);
        do_fetch(1, 32'h1111_2222, 16'h0001, 16'h0002, 1'b0, 0, 16'h0);
        do_fetch(2, 32'h3333_4444, 16'h0002, 16'h0003, 1'b0, 0, 16'h0);
        do_fetch(5, 32'h5555_6666, 16'h0003, 16'h0004, 1'b0, 0, 16'h0);

        // Stray ack in IDLE must not touch ir_data.
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_hold", ir_data, 32'h5555_6666);

        // Branch and fetch together in IDLE.
        do_fetch(0, 32'h0040_0040, 16'h0040, 16'h0041, 1'b1, 0, 16'h0040);

        // Plain branch in IDLE, then branch during REQ.
        br_taken = 1'b1;
        br_addr  = 16'h0010;
        tick();
        br_taken = 1'b0;
        check("idle_br_pc", 32'(pc_out), 32'h10);
        check("idle_br_busy", 32'(busy), 32'd0);
        do_fetch(2, 32'h0010_ABCD, 16'h0010, 16'h0100, 1'b0, 1, 16'h0100);
        // Three branches in REQ: the last one wins.
        do_fetch(3, 32'h0100_0001, 16'h0100, 16'h0202, 1'b0, 3, 16'h0200);

        // Wrap at the top of the address space.
        br_taken = 1'b1;
        br_addr  = 16'hFFFF;
        tick();
        br_taken = 1'b0;
        do_fetch(0, 32'hFFFF_0000, 16'hFFFF, 16'h0000, 1'b0, 0, 16'h0);
        do_fetch(0, 32'h0000_1234, 16'h0000, 16'h0001, 1'b0, 0, 16'h0);

        // Reset in the middle of a request drops it.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("midrst_req", 32'(mem_req), 32'd1);
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_low", 32'(mem_req), 32'd0);
        check("midrst_pc", 32'(pc_out), 32'd0);
        tick();
        check("midrst_no_load", 32'(ir_load), 32'd0);

        // Timeout: exactly 15 REQ cycles without ack.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        check("timeout_cycles", 32'(n), 32'd15);
        check("fault_set", 32'(fault), 32'd1);
        check("fault_req_low", 32'(mem_req), 32'd0);
        check("fault_busy", 32'(busy), 32'd1);
        fetch_req = 1'b1;
        br_taken  = 1'b1;
        br_addr   = 16'h0055;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fault_ignore_req", 32'(mem_req), 32'd0);
            check("fault_ignore_pc", 32'(pc_out), 32'd0);
            check("fault_sticky", 32'(fault), 32'd1);
        end
        fetch_req = 1'b0;
        br_taken  = 1'b0;
        rst_f     = 1'b0;
        tick();
        rst_f = 1'b1;
        check("fault_clr", 32'(fault), 32'd0);
        check("fault_clr_busy", 32'(busy), 32'd0);
        check("fault_clr_pc", 32'(pc_out), 32'd0);

        do_fetch(1, 32'hCAFE_F00D, 16'h0000, 16'h0001, 1'b0, 0, 16'h0);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
